// File: rtl/ftb_update_ctrl_pkg.sv
// Frontend shared package: update/entry types, FTB entry encode/decode helpers,
// encodability check and the update-controller state enum.
package ftb_update_ctrl_pkg;

  localparam int XLEN               = 32;
  localparam int FTB_FALLTHRU_WIDTH = 4;
  localparam int FTB_TARGET_WIDTH   = 12;

  typedef enum logic [1:0] {
    TAR_FIT = 2'd0,
    TAR_OVF = 2'd1,
    TAR_UDF = 2'd2
  } tar_stat_e;

  typedef enum logic [1:0] {
    UPD_IDLE,
    UPD_READ,
    UPD_CMP,
    UPD_WRITE
  } upd_state_e;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    logic [XLEN-1:0] fallthru;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispred;
    logic [1:0]      branch_type;
  } BPupdateInfo_t;

  typedef struct packed {
    logic [FTB_FALLTHRU_WIDTH-1:0] fallthruAddr;
    logic                          carry;
    logic [FTB_TARGET_WIDTH-1:0]   targetAddr;
    tar_stat_e                     tarStat;
    logic [1:0]                    branch_type;
  } ftbInfo_t;

  // Difference of the address bits above the stored field, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] upper_diff(input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b,
                                                 input int lsb);
    return (a >> lsb) - (b >> lsb);
  endfunction

  function automatic logic [XLEN-1:0] decode_fallthru(input logic [XLEN-1:0] start,
                                                      input ftbInfo_t info);
    logic [XLEN-1:0] up;
    up = (start >> (FTB_FALLTHRU_WIDTH + 1)) + XLEN'(info.carry);
    return (up << (FTB_FALLTHRU_WIDTH + 1)) | (XLEN'(info.fallthruAddr) << 1);
  endfunction

  function automatic logic [XLEN-1:0] decode_target(input logic [XLEN-1:0] start,
                                                    input ftbInfo_t info);
    logic [XLEN-1:0] up;
    up = start >> (FTB_TARGET_WIDTH + 1);
    case (info.tarStat)
      TAR_OVF: up = up + XLEN'(1);
      TAR_UDF: up = up - XLEN'(1);
      default: up = up;
    endcase
    return (up << (FTB_TARGET_WIDTH + 1)) | (XLEN'(info.targetAddr) << 1);
  endfunction

  function automatic logic ftb_encodable(input BPupdateInfo_t u);
    logic [XLEN-1:0] fd;
    logic [XLEN-1:0] td;
    logic            ft_ok;
    logic            tg_ok;
    fd    = upper_diff(u.fallthru, u.startAddr, FTB_FALLTHRU_WIDTH + 1);
    td    = upper_diff(u.target, u.startAddr, FTB_TARGET_WIDTH + 1);
    ft_ok = (fd == '0) || (fd == XLEN'(1));
    tg_ok = (td == '0) || (td == XLEN'(1)) || (td == '1);
    return ft_ok && (!u.taken || tg_ok);
  endfunction

  function automatic ftbInfo_t encode_ftb_info(input BPupdateInfo_t u);
    ftbInfo_t        e;
    logic [XLEN-1:0] fd;
    logic [XLEN-1:0] td;
    fd             = upper_diff(u.fallthru, u.startAddr, FTB_FALLTHRU_WIDTH + 1);
    td             = upper_diff(u.target, u.startAddr, FTB_TARGET_WIDTH + 1);
    e.fallthruAddr = u.fallthru[FTB_FALLTHRU_WIDTH:1];
    e.carry        = (fd != '0);
    e.targetAddr   = u.target[FTB_TARGET_WIDTH:1];
    if (td == XLEN'(1))  e.tarStat = TAR_OVF;
    else if (td == '1)   e.tarStat = TAR_UDF;
    else                 e.tarStat = TAR_FIT;
    e.branch_type  = u.branch_type;
    return e;
  endfunction

  function automatic logic [1:0] counter_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    else       return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/ftb_upd_fifo.sv
// Small synchronous FIFO, generic over payload type; full/empty come from the
// registered occupancy count. DEPTH must be a power of two, at least 2.
module ftb_upd_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ftb_update_ctrl.sv
// FTB update controller: queues resolved branch updates, reads the target set,
// picks a way, and writes the encoded entry back one update at a time.
module ftb_update_ctrl
  import ftb_update_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int FTB_IDX_WIDTH = 9,
  parameter int FTB_WAYS      = 4,
  parameter int FTB_TAG_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_upd_vld,
  output logic                                    o_upd_rdy,
  input  BPupdateInfo_t                           i_upd_info,
  output logic                                    o_rd_req,
  output logic [FTB_IDX_WIDTH-1:0]                o_rd_idx,
  input  logic [FTB_WAYS-1:0]                     i_rd_vld,
  input  logic [FTB_WAYS-1:0][FTB_TAG_WIDTH-1:0]  i_rd_tag,
  input  logic [FTB_WAYS-1:0][1:0]                i_rd_scnt,
  input  logic                                    i_arr_busy,
  output logic                                    o_wr_req,
  output logic [FTB_IDX_WIDTH-1:0]                o_wr_idx,
  output logic [FTB_WAYS-1:0]                     o_wr_way,
  output logic [FTB_TAG_WIDTH-1:0]                o_wr_tag,
  output ftbInfo_t                                o_wr_entry,
  output logic [1:0]                              o_wr_scnt,
  output logic [15:0]                             o_drop_cnt,
  output logic                                    o_idle
);

  localparam int WAY_W = (FTB_WAYS > 1) ? $clog2(FTB_WAYS) : 1;

  upd_state_e               state;
  upd_state_e               state_nxt;
  BPupdateInfo_t            head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic [FTB_IDX_WIDTH-1:0] head_idx;
  logic [FTB_TAG_WIDTH-1:0] head_tag;
  logic                     hit;
  logic [WAY_W-1:0]         hit_way;
  logic                     has_inv;
  logic [WAY_W-1:0]         inv_way;
  logic [WAY_W-1:0]         sel_way;
  logic [WAY_W-1:0]         rr_ptr;
  logic [1:0]               old_scnt;
  logic [1:0]               hit_scnt;
  logic [1:0]               sel_scnt;
  logic                     encodable;
  logic                     skip;
  logic                     evict;

  ftb_upd_fifo #(
    .T     (BPupdateInfo_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (i_upd_vld),
    .push_data (i_upd_info),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_idx  = head.startAddr[FTB_IDX_WIDTH:1];
  assign head_tag  = head.startAddr[FTB_IDX_WIDTH+FTB_TAG_WIDTH:FTB_IDX_WIDTH+1];
  assign o_upd_rdy = !fifo_full;
  assign o_idle    = fifo_empty && (state == UPD_IDLE);
  assign o_rd_idx  = (state == UPD_READ) ? head_idx : '0;

  // Scan from the top way down so the lowest matching/invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = FTB_WAYS - 1; w >= 0; w--) begin
      if (i_rd_vld[w] && (i_rd_tag[w] == head_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!i_rd_vld[w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign sel_way   = hit ? hit_way : (has_inv ? inv_way : rr_ptr);
  assign old_scnt  = i_rd_scnt[hit_way];
  assign hit_scnt  = counter_update(old_scnt, head.taken);
  assign sel_scnt  = hit ? hit_scnt : (head.taken ? 2'd2 : 2'd1);
  assign encodable = ftb_encodable(head);
  assign skip      = hit && (hit_scnt == old_scnt) && !head.mispred;
  assign evict     = !hit && !has_inv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UPD_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    o_rd_req  = 1'b0;
    o_wr_req  = 1'b0;
    case (state)
      UPD_IDLE: begin
        if (!fifo_empty) state_nxt = UPD_READ;
      end
      UPD_READ: begin
        if (!i_arr_busy) begin
          o_rd_req  = 1'b1;
          state_nxt = UPD_CMP;
        end
      end
      UPD_CMP: begin
        fifo_pop  = 1'b1;
        state_nxt = (!encodable || skip) ? UPD_IDLE : UPD_WRITE;
      end
      UPD_WRITE: begin
        if (!i_arr_busy) begin
          o_wr_req  = 1'b1;
          state_nxt = UPD_IDLE;
        end
      end
      default: state_nxt = UPD_IDLE;
    endcase
  end

  // Write fields are captured once in CMP and held through any WRITE stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wr_idx   <= '0;
      o_wr_way   <= '0;
      o_wr_tag   <= '0;
      o_wr_entry <= '0;
      o_wr_scnt  <= '0;
      o_drop_cnt <= '0;
      rr_ptr     <= '0;
    end else if (state == UPD_CMP) begin
      if (!encodable) begin
        if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      end else if (!skip) begin
        o_wr_idx   <= head_idx;
        o_wr_way   <= FTB_WAYS'(1) << sel_way;
        o_wr_tag   <= head_tag;
        o_wr_entry <= encode_ftb_info(head);
        o_wr_scnt  <= sel_scnt;
        if (evict) rr_ptr <= (rr_ptr == WAY_W'(FTB_WAYS - 1)) ? '0 : rr_ptr + WAY_W'(1);
      end
    end
  end

endmodule

// File: doc/ftb_update_ctrl.md
FTB_UPDATE_CTRL -- requirements
Module: ftb_update_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: update queue entries, power of two.
REQ-002 SHALL have parameter FTB_IDX_WIDTH, default 9: set index bits; index = startAddr[FTB_IDX_WIDTH:1].
REQ-003 SHALL have parameter FTB_WAYS, default 4: associativity.
REQ-004 SHALL have parameter FTB_TAG_WIDTH, default 16: tag = startAddr[FTB_IDX_WIDTH+FTB_TAG_WIDTH:FTB_IDX_WIDTH+1].
REQ-005 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- i_upd_vld  in  1  update request valid.
- o_upd_rdy  out  1  queue can accept.
- i_upd_info  in  BPupdateInfo_t  resolved branch info.
- o_rd_req  in/out: out  1  FTB set read.
- o_rd_idx  out  FTB_IDX_WIDTH  read set.
- i_rd_vld  in  FTB_WAYS  per-way valid, returned 1 cycle after o_rd_req.
- i_rd_tag  in  FTB_WAYS x FTB_TAG_WIDTH  per-way tags, same timing.
- i_rd_scnt  in  FTB_WAYS x 2  per-way counters, same timing.
- i_arr_busy  in  1  predictor owns the array this cycle.
- o_wr_req  out  1  entry write.
- o_wr_idx  out  FTB_IDX_WIDTH  write set.
- o_wr_way  out  FTB_WAYS  one-hot way.
- o_wr_tag  out  FTB_TAG_WIDTH  tag.
- o_wr_entry  out  ftbInfo_t  encoded entry.
- o_wr_scnt  out  2  counter.
- o_drop_cnt  out  16  saturating count of unencodable updates.
- o_idle  out  1  queue empty and FSM in IDLE.

Function
REQ-006 SHALL push i_upd_info into the FIFO when i_upd_vld && o_upd_rdy; o_upd_rdy = !full, from registered count only.
REQ-007 SHALL run FSM IDLE->READ->CMP->WRITE->IDLE, one update at a time, FIFO head popped on leaving CMP.
REQ-008 IDLE: go READ when FIFO non-empty.
REQ-009 READ: assert o_rd_req for 1 cycle when !i_arr_busy, then go CMP; hold otherwise.
REQ-010 CMP: capture read data.
- Unencodable: go IDLE, no write, o_drop_cnt+1 (saturates at 0xFFFF).
- Hit way with counter already at the counterUpdate result and !mispred: go IDLE, no write.
- Otherwise: go WRITE.
REQ-011 WRITE: assert o_wr_req for 1 cycle when !i_arr_busy, then go IDLE; hold all write fields stable while stalled.
REQ-012 Minimum FIFO-head-to-o_wr_req latency: 2 cycles (READ, CMP, write in 3rd); throughput one update per 4 cycles.
REQ-013 Encoding is the exact inverse of the fallthrough and target decode functions.
- fallthruAddr = fallthru[FTB_FALLTHRU_WIDTH:1].
- carry = (fallthru[XLEN-1:FTB_FALLTHRU_WIDTH+1] != start's same bits).
- targetAddr = target[FTB_TARGET_WIDTH:1].
- tarStat: FIT / OVF / UDF for upper-bit difference 0 / +1 / -1.
- branch_type copied from the update.
REQ-014 An update is unencodable when the fallthrough upper-bit difference is not 0 or +1, or when taken and the target upper-bit difference is not in {-1,0,+1}; compares use full XLEN upper bits.
REQ-015 Way selection, in order:
- tag hit (i_rd_vld && tag match) on the lowest matching way;
- else the lowest invalid way;
- else the round-robin pointer, which advances (mod FTB_WAYS) only on eviction.
REQ-016 Counter:
- on hit, o_wr_scnt = counterUpdate(i_rd_scnt[way], taken);
- on allocate, 2 if taken else 1.
REQ-017 Same-index back-to-back updates SHALL observe the prior write, which serialization guarantees; no bypass is required.
REQ-018 A push to a full FIFO is impossible by REQ-006; a simultaneous push and pop at non-full SHALL keep the count unchanged.

Reset
REQ-019 On rst low, immediately:
- FIFO empty, FSM IDLE, RR pointer 0, o_drop_cnt 0;
- o_rd_req=0, o_wr_req=0, all other outputs 0, o_upd_rdy=1 and o_idle=1 after release.
REQ-020 Reset mid-operation SHALL abandon the in-flight update with no write issued after reset asserts.

Structure
REQ-021 The FSM state enum, the ftbInfo_t encode function and the encodability check SHALL live in the frontend shared package, beside the existing decode functions.
REQ-022 The queue SHALL be sub-module ftb_upd_fifo, generic over payload type and depth.

Verification
REQ-023 Configure FTB_FALLTHRU_WIDTH=4; start 0x8000001C, fallthru 0x80000024, miss, empty set -> write to way 0 with fallthruAddr=0x2, carry=1, scnt per taken.
REQ-024 Configure FTB_TARGET_WIDTH=12; start 0x80002000, target 0x80001FF0, taken -> tarStat=UDF, targetAddr=0xFF8, scnt=2.
REQ-025 Hit on way 2 with scnt=3, taken, !mispred -> no o_wr_req; same with mispred=1 -> write way 2, scnt=3.
REQ-026 Target 0x80010000 from start 0x80000000 -> no write, o_drop_cnt=1.
REQ-027 i_arr_busy high 5 cycles during WRITE -> o_wr_req delayed 5 cycles, fields stable; 5 pushes at depth 4 -> o_upd_rdy low after the 4th until the first pop.
REQ-028 All ways valid and missing, 5 allocations -> ways 0,1,2,3,0; rst asserted in CMP -> no subsequent o_wr_req, o_idle=1.
